// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB sequencing over an 8-entry register file.
// Bus-facing outputs are registered from the next state so they are glitch-free and stable per state.
module cpu_multicycle #(
  parameter int              XLEN     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            halted,
  output logic [31:0]     instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [1:0]      CLS_MEM = 2'b00;
  localparam logic [1:0]      CLS_ALU = 2'b01;
  localparam logic [1:0]      CLS_BR  = 2'b10;
  localparam logic [1:0]      CLS_SYS = 2'b11;
  localparam logic [XLEN-1:0] ONE     = XLEN'(1'b1);

  state_t          state_r, next_state_s;
  logic [31:0]     ir_r;
  logic [XLEN-1:0] pc_r, npc_r, a_r, b_r, res_r, mdr_r;
  logic [XLEN-1:0] rf_r [8];
  logic [31:0]     instret_r;
  logic            imem_req_r, dmem_req_r, dmem_we_r, halted_r;
  logic [XLEN-1:0] imem_addr_r, dmem_addr_r, dmem_wdata_r;

  logic [1:0]      cls_s;
  logic [3:0]      op_s;
  logic [2:0]      rd_s, rs1_s, rs2_s;
  logic            imm_sel_s, is_ldst_s, rd_we_s;
  logic [XLEN-1:0] imm_s, opb_s, alu_s, pc_inc_s, target_s, exec_npc_s, exec_res_s, wb_data_s;
  logic [4:0]      shamt_s;

  assign cls_s     = ir_r[31:30];
  assign op_s      = ir_r[29:26];
  assign rd_s      = ir_r[25:23];
  assign rs1_s     = ir_r[22:20];
  assign rs2_s     = ir_r[19:17];
  assign imm_sel_s = ir_r[16];
  assign imm_s     = XLEN'($signed(ir_r[15:0]));

  assign is_ldst_s = (cls_s == CLS_MEM) && ((op_s == 4'd0) || (op_s == 4'd1));
  assign rd_we_s   = (cls_s == CLS_ALU) || ((cls_s == CLS_MEM) && (op_s == 4'd0)) ||
                     ((cls_s == CLS_BR) && (op_s == 4'd4));
  assign wb_data_s = (cls_s == CLS_MEM) ? mdr_r : res_r;

  // ALU: shifts past the word width fall out naturally as zero or sign fill
  always_comb begin
    opb_s   = imm_sel_s ? imm_s : b_r;
    shamt_s = opb_s[4:0];
    alu_s   = '0;
    case (op_s)
      4'd0:    alu_s = a_r + opb_s;
      4'd1:    alu_s = a_r - opb_s;
      4'd2:    alu_s = a_r & opb_s;
      4'd3:    alu_s = a_r | opb_s;
      4'd4:    alu_s = a_r ^ opb_s;
      4'd5:    alu_s = a_r << shamt_s;
      4'd6:    alu_s = a_r >> shamt_s;
      4'd7:    alu_s = $signed(a_r) >>> shamt_s;
      4'd8:    alu_s = {{(XLEN-1){1'b0}}, ($signed(a_r) < $signed(opb_s))};
      4'd9:    alu_s = {{(XLEN-1){1'b0}}, (a_r < opb_s)};
      default: alu_s = '0;
    endcase
  end

  // Execute-stage result (ALU value, memory address or link) and next PC
  always_comb begin
    pc_inc_s   = pc_r + ONE;
    target_s   = pc_r + imm_s;
    exec_npc_s = pc_inc_s;
    exec_res_s = alu_s;
    case (cls_s)
      CLS_MEM: exec_res_s = a_r + imm_s;
      CLS_BR: begin
        exec_res_s = pc_inc_s;
        case (op_s)
          4'd0: exec_npc_s = target_s;
          4'd1: begin
            if (a_r == b_r) exec_npc_s = target_s;
            else            exec_npc_s = pc_inc_s;
          end
          4'd2: begin
            if (a_r != b_r) exec_npc_s = target_s;
            else            exec_npc_s = pc_inc_s;
          end
          4'd3:    exec_npc_s = a_r;
          4'd4:    exec_npc_s = target_s;
          default: exec_npc_s = pc_inc_s;
        endcase
      end
      default: exec_res_s = alu_s;
    endcase
  end

  // Next-state logic; a fetch only completes once the request is actually on the bus
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH: begin
        if (imem_req_r && imem_ready) next_state_s = DECODE;
        else                          next_state_s = FETCH;
      end
      DECODE: next_state_s = EXEC;
      EXEC: begin
        if (cls_s == CLS_SYS) next_state_s = HALT;
        else if (is_ldst_s)   next_state_s = MEM;
        else                  next_state_s = WB;
      end
      MEM: begin
        if (dmem_ready) next_state_s = WB;
        else            next_state_s = MEM;
      end
      WB:      next_state_s = FETCH;
      HALT:    next_state_s = HALT;
      default: next_state_s = FETCH;
    endcase
  end

  // State register and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FETCH;
      imem_req_r   <= 1'b0;
      imem_addr_r  <= '0;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= '0;
      dmem_wdata_r <= '0;
      halted_r     <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      imem_req_r  <= (next_state_s == FETCH);
      imem_addr_r <= (next_state_s == FETCH) ? ((state_r == WB) ? npc_r : pc_r) : '0;
      dmem_req_r  <= (next_state_s == MEM);
      halted_r    <= (next_state_s == HALT);
      if (next_state_s == MEM) begin
        if (state_r == EXEC) begin
          dmem_addr_r  <= exec_res_s;
          dmem_we_r    <= (op_s == 4'd1);
          dmem_wdata_r <= (op_s == 4'd1) ? b_r : '0;
        end
      end else begin
        dmem_we_r    <= 1'b0;
        dmem_addr_r  <= '0;
        dmem_wdata_r <= '0;
      end
    end
  end

  // Datapath, register file and retirement counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r      <= RESET_PC;
      npc_r     <= '0;
      ir_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      mdr_r     <= '0;
      instret_r <= '0;
      for (int i = 0; i < 8; i++) rf_r[i] <= '0;
    end else begin
      case (state_r)
        FETCH: if (imem_req_r && imem_ready) ir_r <= imem_rdata;
        DECODE: begin
          a_r <= rf_r[rs1_s];
          b_r <= rf_r[rs2_s];
        end
        EXEC: begin
          res_r <= exec_res_s;
          npc_r <= exec_npc_s;
          if (cls_s == CLS_SYS) instret_r <= instret_r + 32'd1;
        end
        MEM: if (dmem_ready && !dmem_we_r) mdr_r <= dmem_rdata;
        WB: begin
          pc_r      <= npc_r;
          instret_r <= instret_r + 32'd1;
          if (rd_we_s && (rd_s != 3'd0)) rf_r[rd_s] <= wb_data_s;
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = imem_addr_r;
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_wdata = dmem_wdata_r;
  assign halted     = halted_r;
  assign instret    = instret_r;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench: a 16-bit core with wait-state data memory and an 8-bit core with RESET_PC=0x10.
module tb_cpu_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  logic        imem_req_a, imem_ready_a, dmem_req_a, dmem_we_a, dmem_ready_a, halted_a;
  logic [15:0] imem_addr_a, dmem_addr_a, dmem_wdata_a, dmem_rdata_a;
  logic [31:0] imem_rdata_a, instret_a;

  logic        imem_req_b, imem_ready_b, dmem_req_b, dmem_we_b, dmem_ready_b, halted_b;
  logic [7:0]  imem_addr_b, dmem_addr_b, dmem_wdata_b, dmem_rdata_b;
  logic [31:0] imem_rdata_b, instret_b;

  logic [31:0] rom_a [64];
  logic [15:0] ram_a [256];
  logic [31:0] rom_b [32];

  int dwait_a = 0;
  int dcnt_a = 0, we_cyc_a = 0, overlap_a = 0, halt_fetch_a = 0;
  logic [15:0] fetch_q [$];
  logic [15:0] wa_a [$];
  logic [15:0] wd_a [$];
  logic [7:0]  wa_b [$];
  logic [7:0]  wd_b [$];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc, fb, wr0;

  int exp_f1 [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 9};
  int exp_f2 [5]  = '{0, 1, 4, 2, 3};
  int exp_wa1 [4] = '{16'h20, 16'h21, 16'h22, 16'h23};
  int exp_wd1 [4] = '{12, 12, 0, 9};
  int exp_wab [5] = '{1, 2, 3, 4, 5};
  int exp_wdb [5] = '{8'h00, 8'hFF, 8'h01, 8'h00, 8'h81};

  cpu_multicycle #(.XLEN(16), .RESET_PC(16'h0000)) dut_a (
    .clk(clk), .rst(rst_a),
    .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a), .imem_ready(imem_ready_a),
    .dmem_req(dmem_req_a), .dmem_we(dmem_we_a), .dmem_addr(dmem_addr_a), .dmem_wdata(dmem_wdata_a),
    .dmem_rdata(dmem_rdata_a), .dmem_ready(dmem_ready_a), .halted(halted_a), .instret(instret_a)
  );

  cpu_multicycle #(.XLEN(8), .RESET_PC(8'h10)) dut_b (
    .clk(clk), .rst(rst_b),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b), .imem_ready(imem_ready_b),
    .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_addr(dmem_addr_b), .dmem_wdata(dmem_wdata_b),
    .dmem_rdata(dmem_rdata_b), .dmem_ready(dmem_ready_b), .halted(halted_b), .instret(instret_b)
  );

  assign imem_ready_a = imem_req_a;
  assign imem_rdata_a = rom_a[imem_addr_a[5:0]];
  assign dmem_rdata_a = ram_a[dmem_addr_a[7:0]];
  assign dmem_ready_a = dmem_req_a && (dcnt_a >= dwait_a);

  assign imem_ready_b = imem_req_b;
  assign imem_rdata_b = rom_b[imem_addr_b[4:0]];
  assign dmem_rdata_b = 8'h00;
  assign dmem_ready_b = dmem_req_b;

  // Memory models and bus monitors
  always @(posedge clk) begin
    if (imem_req_a && dmem_req_a) overlap_a <= overlap_a + 1;
    if (halted_a && imem_req_a) halt_fetch_a <= halt_fetch_a + 1;
    if (dmem_we_a) we_cyc_a <= we_cyc_a + 1;
    if (dmem_req_a && !dmem_ready_a) dcnt_a <= dcnt_a + 1;
    else dcnt_a <= 0;
    if (imem_req_a && imem_ready_a && !rst_a) fetch_q.push_back(imem_addr_a);
    if (dmem_req_a && dmem_ready_a && dmem_we_a && !rst_a) begin
      ram_a[dmem_addr_a[7:0]] <= dmem_wdata_a;
      wa_a.push_back(dmem_addr_a);
      wd_a.push_back(dmem_wdata_a);
    end
    if (dmem_req_b && dmem_ready_b && dmem_we_b && !rst_b) begin
      wa_b.push_back(dmem_addr_b);
      wd_b.push_back(dmem_wdata_b);
    end
  end

  function automatic logic [31:0] enc(input logic [1:0] cls, input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2, input logic isel,
                                      input logic [15:0] imm);
    return {cls, op, rd, rs1, rs2, isel, imm};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ret_a(input logic [31:0] target, input int limit, output int n);
    n = 0;
    while (instret_a != target && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    dwait_a = 3;
    rom_a[0]  = enc(2'd1, 4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5);
    rom_a[1]  = enc(2'd1, 4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'd7);
    rom_a[2]  = enc(2'd1, 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0);
    rom_a[3]  = enc(2'd0, 4'd1, 3'd0, 3'd0, 3'd3, 1'b1, 16'h0020);
    rom_a[4]  = enc(2'd0, 4'd0, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0020);
    rom_a[5]  = enc(2'd0, 4'd1, 3'd0, 3'd0, 3'd4, 1'b1, 16'h0021);
    rom_a[6]  = enc(2'd1, 4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'd9);
    rom_a[7]  = enc(2'd0, 4'd1, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0022);
    rom_a[8]  = enc(2'd2, 4'd4, 3'd5, 3'd0, 3'd0, 1'b0, 16'd2);
    rom_a[9]  = enc(2'd3, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0);
    rom_a[10] = enc(2'd0, 4'd1, 3'd0, 3'd0, 3'd5, 1'b1, 16'h0023);
    rom_a[11] = enc(2'd2, 4'd3, 3'd0, 3'd5, 3'd0, 1'b0, 16'd0);

    rom_b[16] = enc(2'd1, 4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h00FF);
    rom_b[17] = enc(2'd1, 4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001);
    rom_b[18] = enc(2'd0, 4'd1, 3'd0, 3'd0, 3'd2, 1'b1, 16'h0001);
    rom_b[19] = enc(2'd1, 4'd0, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0080);
    rom_b[20] = enc(2'd1, 4'd7, 3'd4, 3'd3, 3'd0, 1'b1, 16'h0009);
    rom_b[21] = enc(2'd0, 4'd1, 3'd0, 3'd0, 3'd4, 1'b1, 16'h0002);
    rom_b[22] = enc(2'd1, 4'd0, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0001);
    rom_b[23] = enc(2'd1, 4'd8, 3'd6, 3'd3, 3'd5, 1'b0, 16'h0000);
    rom_b[24] = enc(2'd1, 4'd9, 3'd7, 3'd3, 3'd5, 1'b0, 16'h0000);
    rom_b[25] = enc(2'd0, 4'd1, 3'd0, 3'd0, 3'd6, 1'b1, 16'h0003);
    rom_b[26] = enc(2'd0, 4'd1, 3'd0, 3'd0, 3'd7, 1'b1, 16'h0004);
    rom_b[27] = enc(2'd1, 4'd1, 3'd1, 3'd5, 3'd3, 1'b0, 16'h0000);
    rom_b[28] = enc(2'd0, 4'd1, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0005);
    rom_b[29] = enc(2'd3, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);

    repeat (3) @(negedge clk);
    check_eq("rst_imem_req", imem_req_a, 1'b0);
    check_eq("rst_imem_addr", imem_addr_a, 16'h0000);
    check_eq("rst_dmem_req", dmem_req_a, 1'b0);
    check_eq("rst_dmem_we", dmem_we_a, 1'b0);
    check_eq("rst_dmem_addr", dmem_addr_a, 16'h0000);
    check_eq("rst_dmem_wdata", dmem_wdata_a, 16'h0000);
    check_eq("rst_halted", halted_a, 1'b0);
    check_eq("rst_instret", instret_a, 32'd0);
    check_eq("rst_b_imem_addr", imem_addr_b, 8'h00);

    // Program 1: ALU, store/load with three wait cycles, r0 write, JAL/JR, HALT
    rst_a = 1'b0;
    cyc = 0;
    while (!imem_req_a && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("first_fetch_req", imem_req_a, 1'b1);
    check_eq("first_fetch_addr", imem_addr_a, 16'h0000);
    wait_ret_a(32'd3, 40, cyc);
    check_eq("alu3_instret", instret_a, 32'd3);
    check_eq("alu3_cycles", cyc, 12);
    wait_ret_a(32'd4, 40, cyc);
    check_eq("store_cycles", cyc, 8);
    check_eq("store_we_cycles", we_cyc_a, 4);
    check_eq("store_count", wa_a.size(), 1);
    wait_ret_a(32'd5, 40, cyc);
    check_eq("load_cycles", cyc, 8);
    cyc = 0;
    while (!halted_a && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("p1_halted", halted_a, 1'b1);
    check_eq("p1_instret", instret_a, 32'd12);
    check_eq("p1_nwrites", wa_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("p1_waddr%0d", i), (i < wa_a.size()) ? wa_a[i] : 16'hDEAD, exp_wa1[i]);
      check_eq($sformatf("p1_wdata%0d", i), (i < wd_a.size()) ? wd_a[i] : 16'hDEAD, exp_wd1[i]);
    end
    check_eq("p1_nfetch", fetch_q.size(), 12);
    for (int i = 0; i < 12; i++)
      check_eq($sformatf("p1_fetch%0d", i), (i < fetch_q.size()) ? fetch_q[i] : 16'hDEAD, exp_f1[i]);
    repeat (20) @(negedge clk);
    check_eq("halt_instret_frozen", instret_a, 32'd12);
    check_eq("halt_no_fetch", halt_fetch_a, 0);
    check_eq("halt_imem_req", imem_req_a, 1'b0);

    // Program 2: JMP, taken BEQ backwards, untaken BNE, HALT at PC 3; one-cycle reset out of HALT
    rst_a = 1'b1;
    rom_a[0] = enc(2'd1, 4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd1);
    rom_a[1] = enc(2'd2, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'd3);
    rom_a[2] = enc(2'd2, 4'd2, 3'd0, 3'd1, 3'd1, 1'b0, 16'hFFFE);
    rom_a[3] = enc(2'd3, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0);
    rom_a[4] = enc(2'd2, 4'd1, 3'd0, 3'd1, 3'd1, 1'b0, 16'hFFFE);
    @(negedge clk);
    check_eq("rst1_halted", halted_a, 1'b0);
    check_eq("rst1_instret", instret_a, 32'd0);
    rst_a = 1'b0;
    fb = fetch_q.size();
    cyc = 0;
    while (!halted_a && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("p2_halted", halted_a, 1'b1);
    check_eq("p2_instret", instret_a, 32'd5);
    check_eq("p2_nfetch", fetch_q.size() - fb, 5);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("p2_fetch%0d", i), (fb + i < fetch_q.size()) ? fetch_q[fb + i] : 16'hDEAD, exp_f2[i]);
    check_eq("overlap", overlap_a, 0);

    // Program 3: reset during a stalled store abandons it
    rst_a = 1'b1;
    dwait_a = 10;
    rom_a[0] = enc(2'd1, 4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0055);
    rom_a[1] = enc(2'd0, 4'd1, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0040);
    rom_a[2] = enc(2'd3, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0);
    @(negedge clk);
    rst_a = 1'b0;
    wr0 = wa_a.size();
    cyc = 0;
    while (!dmem_req_a && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("p3_dmem_req", dmem_req_a, 1'b1);
    check_eq("p3_dmem_we", dmem_we_a, 1'b1);
    check_eq("p3_dmem_addr", dmem_addr_a, 16'h0040);
    check_eq("p3_dmem_wdata", dmem_wdata_a, 16'h0055);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check_eq("p3_req_dropped", dmem_req_a, 1'b0);
    check_eq("p3_we_dropped", dmem_we_a, 1'b0);
    check_eq("p3_instret_rst", instret_a, 32'd0);
    check_eq("p3_no_write", wa_a.size(), wr0);
    rst_a = 1'b0;
    dwait_a = 0;
    cyc = 0;
    while (!imem_req_a && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("p3_refetch_addr", imem_addr_a, 16'h0000);
    cyc = 0;
    while (!halted_a && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("p3_instret", instret_a, 32'd3);
    check_eq("p3_nwrites", wa_a.size(), wr0 + 1);
    check_eq("p3_wdata", (wd_a.size() > 0) ? wd_a[wd_a.size() - 1] : 16'hDEAD, 16'h0055);

    // 8-bit core: wraparound, SRA past width, signed/unsigned compare, SUB
    check_eq("b_rst_imem_req", imem_req_b, 1'b0);
    rst_b = 1'b0;
    cyc = 0;
    while (!imem_req_b && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("b_first_fetch_addr", imem_addr_b, 8'h10);
    cyc = 0;
    while (!halted_b && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("b_halted", halted_b, 1'b1);
    check_eq("b_instret", instret_b, 32'd14);
    check_eq("b_nwrites", wa_b.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("b_waddr%0d", i), (i < wa_b.size()) ? wa_b[i] : 8'hEE, exp_wab[i]);
      check_eq($sformatf("b_wdata%0d", i), (i < wd_b.size()) ? wd_b[i] : 8'hEE, exp_wdb[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
